branch_predictor: RTL and testbench

Dynamic branch-direction predictor for the 5-stage RV32 pipeline. Holds a table of 2-bit saturating counters indexed by fetch PC, issues a taken/not-taken prediction in IF, and carries each prediction down IF/ID → ID/EX → EX/MEM. The EX/MEM copy drives `pred_ex_mem`, which the branch control unit compares against the resolved outcome. Counters train when a B-type instruction retires from EX/MEM.

---
 rtl/branch_pkg.sv | 22 ++
 rtl/sat_counter2.sv | 19 +
 rtl/branch_predictor.sv | 109 ++++++++++
 tb/tb_branch_predictor.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch-direction predictor.
package branch_pkg;

    localparam logic [6:0] B_TYPE = 7'b1100011;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Wide enough for the largest table; smaller tables zero-extend.
    localparam int IDX_MAX_W = 8;

    typedef struct packed {
        logic                 v;
        logic                 pred;
        logic [IDX_MAX_W-1:0] idx;
    } pred_stage_t;

    localparam pred_stage_t STAGE_CLR = '0;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter step used on the training path.
module sat_counter2
    import branch_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_inc,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_inc) begin
            if (i_ctr != ST) o_ctr = i_ctr + 2'd1;
        end else begin
            if (i_ctr != SNT) o_ctr = i_ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// 2-bit counter branch predictor with prediction carried IF/ID -> ID/EX -> EX/MEM
// and retire-time training plus saturating branch / mispredict statistics.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    input  logic        if_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [6:0]  res_opcode,
    input  logic        res_taken,
    input  logic        stat_clr,
    output logic        predict_taken,
    output logic        pred_ex_mem,
    output logic        mispredict,
    output logic [15:0] branch_cnt,
    output logic [15:0] miss_cnt
);

    logic [1:0]           r_ctr [ENTRIES];
    pred_stage_t          r_id;
    pred_stage_t          r_ex;
    pred_stage_t          r_em;
    logic [15:0]          r_branch_cnt;
    logic [15:0]          r_miss_cnt;

    logic [IDX_W-1:0]     w_if_idx;
    logic [IDX_MAX_W-1:0] w_if_idx_ext;
    logic                 w_pred;
    logic                 w_retire;
    logic                 w_mispredict;
    logic [1:0]           w_em_ctr;
    logic [1:0]           w_em_ctr_nxt;
    logic                 w_unused_pc;

    assign w_if_idx     = if_pc[IDX_W+1:2];
    assign w_if_idx_ext = IDX_MAX_W'(w_if_idx);
    assign w_unused_pc  = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Table read is the registered value: no bypass from the retire path.
    assign w_pred = if_valid & r_ctr[w_if_idx][1];

    assign w_retire     = r_em.v & (res_opcode == B_TYPE) & ~stall;
    assign w_mispredict = w_retire & (r_em.pred != res_taken);

    always_comb begin
        w_em_ctr = WNT;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_em.idx == IDX_MAX_W'(i)) w_em_ctr = r_ctr[i];
        end
    end

    sat_counter2 u_sat (
        .i_ctr (w_em_ctr),
        .i_inc (res_taken),
        .o_ctr (w_em_ctr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= WNT;
        end else if (w_retire) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (r_em.idx == IDX_MAX_W'(i)) r_ctr[i] <= w_em_ctr_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id <= STAGE_CLR;
            r_ex <= STAGE_CLR;
            r_em <= STAGE_CLR;
        end else if (flush) begin
            r_id <= STAGE_CLR;
            r_ex <= STAGE_CLR;
            r_em <= STAGE_CLR;
        end else if (!stall) begin
            r_id <= '{v: if_valid, pred: w_pred, idx: w_if_idx_ext};
            r_ex <= r_id;
            r_em <= r_ex;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
        end else if (stat_clr) begin
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
        end else if (w_retire) begin
            if (r_branch_cnt != 16'hFFFF) r_branch_cnt <= r_branch_cnt + 16'd1;
            if (w_mispredict && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign predict_taken = w_pred;
    assign pred_ex_mem   = r_em.v & r_em.pred;
    assign mispredict    = w_mispredict;
    assign branch_cnt    = r_branch_cnt;
    assign miss_cnt      = r_miss_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor against an integer reference model.
module tb_branch_predictor;

    localparam int         ENTRIES = 16;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        stall;
    logic        flush;
    logic [6:0]  res_opcode;
    logic        res_taken;
    logic        stat_clr;
    logic        predict_taken;
    logic        pred_ex_mem;
    logic        mispredict;
    logic [15:0] branch_cnt;
    logic [15:0] miss_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit v;
        bit pred;
        int idx;
    } mstage_t;

    mstage_t ms [3];
    int      mctr [ENTRIES];
    int      mbr;
    int      mmiss;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .if_valid      (if_valid),
        .stall         (stall),
        .flush         (flush),
        .res_opcode    (res_opcode),
        .res_taken     (res_taken),
        .stat_clr      (stat_clr),
        .predict_taken (predict_taken),
        .pred_ex_mem   (pred_ex_mem),
        .mispredict    (mispredict),
        .branch_cnt    (branch_cnt),
        .miss_cnt      (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic int m_idx();
        return int'((if_pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_pt();
        return if_valid && (mctr[m_idx()] >= 2);
    endfunction

    function automatic bit m_retire();
        return ms[2].v && (res_opcode == OP_BR) && !stall;
    endfunction

    function automatic bit m_misp();
        return m_retire() && (ms[2].pred != res_taken);
    endfunction

    function automatic bit m_pem();
        return ms[2].v ? ms[2].pred : 1'b0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) mctr[i] = 1;
        for (int i = 0; i < 3; i++) ms[i] = '{0, 0, 0};
        mbr   = 0;
        mmiss = 0;
    endfunction

    function automatic void model_edge();
        bit rt;
        bit mp;
        bit pt;
        int ix;
        rt = m_retire();
        mp = m_misp();
        pt = m_pt();
        ix = m_idx();
        if (rt) begin
            if (res_taken) mctr[ms[2].idx] = (mctr[ms[2].idx] < 3) ? mctr[ms[2].idx] + 1 : 3;
            else           mctr[ms[2].idx] = (mctr[ms[2].idx] > 0) ? mctr[ms[2].idx] - 1 : 0;
        end
        if (stat_clr) begin
            mbr   = 0;
            mmiss = 0;
        end else if (rt) begin
            if (mbr < 65535) mbr++;
            if (mp && mmiss < 65535) mmiss++;
        end
        if (flush) begin
            for (int i = 0; i < 3; i++) ms[i] = '{0, 0, 0};
        end else if (!stall) begin
            ms[2] = ms[1];
            ms[1] = ms[0];
            ms[0] = '{if_valid, pt, ix};
        end
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic drive_idle();
        if_valid   = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        res_opcode = 7'h00;
        res_taken  = 1'b0;
        stat_clr   = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        if_pc    = 32'h40;
        if_valid = 1'b1;
        step();
        step();
        #1;
        checks++; if (predict_taken !== 1'b0) begin failures++; $display("FAIL reset_pred got=%0b exp=0", predict_taken); end
        checks++; if (pred_ex_mem !== 1'b0) begin failures++; $display("FAIL reset_pem got=%0b exp=0", pred_ex_mem); end
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL reset_misp got=%0b exp=0", mispredict); end
        checks++; if (branch_cnt !== 16'h0) begin failures++; $display("FAIL reset_bcnt got=%0h exp=0", branch_cnt); end
        checks++; if (miss_cnt !== 16'h0) begin failures++; $display("FAIL reset_mcnt got=%0h exp=0", miss_cnt); end
        rst_n = 1'b1;
        drive_idle();
        step();
    endtask

    task automatic test_train();
        for (int k = 0; k < 3; k++) begin
            if_pc    = 32'h40;
            if_valid = 1'b1;
            #1;
            checks++; if (predict_taken !== m_pt()) begin failures++; $display("FAIL train_if_pred[%0d] got=%0b exp=%0b", k, predict_taken, m_pt()); end
            step();
            if_valid = 1'b0;
            step();
            step();
            res_opcode = OP_BR;
            res_taken  = 1'b1;
            #1;
            checks++; if (pred_ex_mem !== m_pem()) begin failures++; $display("FAIL train_pem[%0d] got=%0b exp=%0b", k, pred_ex_mem, m_pem()); end
            checks++; if (mispredict !== m_misp()) begin failures++; $display("FAIL train_misp[%0d] got=%0b exp=%0b", k, mispredict, m_misp()); end
            step();
            res_opcode = 7'h00;
            #1;
            checks++; if (branch_cnt !== 16'(mbr)) begin failures++; $display("FAIL train_bcnt[%0d] got=%0h exp=%0h", k, branch_cnt, mbr); end
            checks++; if (miss_cnt !== 16'(mmiss)) begin failures++; $display("FAIL train_mcnt[%0d] got=%0h exp=%0h", k, miss_cnt, mmiss); end
        end
        if_pc    = 32'h40;
        if_valid = 1'b1;
        #1;
        checks++; if (predict_taken !== 1'b1) begin failures++; $display("FAIL train_taken got=%0b exp=1", predict_taken); end
        step();
        if_valid = 1'b0;
        step();
        step();
        res_opcode = OP_BR;
        res_taken  = 1'b0;
        #1;
        checks++; if (mispredict !== m_misp()) begin failures++; $display("FAIL train_nt_misp got=%0b exp=%0b", mispredict, m_misp()); end
        step();
        res_opcode = 7'h00;
        if_pc      = 32'h40;
        if_valid   = 1'b1;
        #1;
        checks++; if (predict_taken !== 1'b1) begin failures++; $display("FAIL train_sat_hold got=%0b exp=1", predict_taken); end
        if_valid = 1'b0;
    endtask

    task automatic test_misp_flush();
        if_pc    = 32'h84;
        if_valid = 1'b1;
        #1;
        checks++; if (predict_taken !== m_pt()) begin failures++; $display("FAIL mf_if_pred got=%0b exp=%0b", predict_taken, m_pt()); end
        step();
        if_pc = 32'h40;
        step();
        step();
        if_valid   = 1'b0;
        res_opcode = OP_BR;
        res_taken  = 1'b1;
        flush      = 1'b1;
        #1;
        checks++; if (pred_ex_mem !== 1'b0) begin failures++; $display("FAIL mf_pem got=%0b exp=0", pred_ex_mem); end
        checks++; if (mispredict !== m_misp()) begin failures++; $display("FAIL mf_misp got=%0b exp=%0b", mispredict, m_misp()); end
        step();
        flush = 1'b0;
        #1;
        checks++; if (miss_cnt !== 16'(mmiss)) begin failures++; $display("FAIL mf_mcnt got=%0h exp=%0h", miss_cnt, mmiss); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (mispredict !== m_misp()) begin failures++; $display("FAIL mf_drain_misp[%0d] got=%0b exp=%0b", k, mispredict, m_misp()); end
            checks++; if (pred_ex_mem !== m_pem()) begin failures++; $display("FAIL mf_drain_pem[%0d] got=%0b exp=%0b", k, pred_ex_mem, m_pem()); end
            step();
        end
        res_opcode = 7'h00;
        #1;
        checks++; if (branch_cnt !== 16'(mbr)) begin failures++; $display("FAIL mf_bcnt got=%0h exp=%0h", branch_cnt, mbr); end
        if_pc    = 32'h84;
        if_valid = 1'b1;
        #1;
        checks++; if (predict_taken !== m_pt()) begin failures++; $display("FAIL mf_trained got=%0b exp=%0b", predict_taken, m_pt()); end
        if_valid = 1'b0;
    endtask

    task automatic test_stall();
        int b0;
        if_pc    = 32'h48;
        if_valid = 1'b1;
        step();
        if_valid = 1'b0;
        step();
        step();
        b0         = mbr;
        stall      = 1'b1;
        res_opcode = OP_BR;
        res_taken  = 1'b1;
        if_pc      = 32'h84;
        if_valid   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (mispredict !== m_misp()) begin failures++; $display("FAIL stall_misp[%0d] got=%0b exp=%0b", k, mispredict, m_misp()); end
            step();
            checks++; if (branch_cnt !== 16'(b0)) begin failures++; $display("FAIL stall_bcnt[%0d] got=%0h exp=%0h", k, branch_cnt, b0); end
        end
        stall    = 1'b0;
        if_valid = 1'b0;
        #1;
        checks++; if (mispredict !== m_misp()) begin failures++; $display("FAIL stall_rel_misp got=%0b exp=%0b", mispredict, m_misp()); end
        step();
        step();
        res_opcode = 7'h00;
        #1;
        checks++; if (branch_cnt !== 16'(b0 + 1)) begin failures++; $display("FAIL stall_once got=%0h exp=%0h", branch_cnt, b0 + 1); end
        if_pc    = 32'h48;
        if_valid = 1'b1;
        #1;
        checks++; if (predict_taken !== m_pt()) begin failures++; $display("FAIL stall_trained got=%0b exp=%0b", predict_taken, m_pt()); end
        if_valid = 1'b0;
    endtask

    task automatic test_flush_stall();
        for (int k = 0; k < 3; k++) begin
            if_pc    = 32'h40 + 32'(4 * k);
            if_valid = 1'b1;
            step();
        end
        if_valid   = 1'b0;
        flush      = 1'b1;
        stall      = 1'b1;
        res_opcode = 7'h33;
        #1;
        checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL fs_misp got=%0b exp=0", mispredict); end
        step();
        flush      = 1'b0;
        stall      = 1'b0;
        res_opcode = OP_BR;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (pred_ex_mem !== m_pem()) begin failures++; $display("FAIL fs_pem[%0d] got=%0b exp=%0b", k, pred_ex_mem, m_pem()); end
            checks++; if (mispredict !== m_misp()) begin failures++; $display("FAIL fs_drain_misp[%0d] got=%0b exp=%0b", k, mispredict, m_misp()); end
            step();
        end
        res_opcode = 7'h00;
        checks++; if (branch_cnt !== 16'(mbr)) begin failures++; $display("FAIL fs_bcnt got=%0h exp=%0h", branch_cnt, mbr); end
    endtask

    task automatic test_reset_midop();
        if_pc    = 32'h40;
        if_valid = 1'b1;
        step();
        step();
        step();
        #1;
        checks++; if (pred_ex_mem !== m_pem()) begin failures++; $display("FAIL mid_pem_pre got=%0b exp=%0b", pred_ex_mem, m_pem()); end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (pred_ex_mem !== 1'b0) begin failures++; $display("FAIL mid_pem got=%0b exp=0", pred_ex_mem); end
        checks++; if (predict_taken !== m_pt()) begin failures++; $display("FAIL mid_pred got=%0b exp=%0b", predict_taken, m_pt()); end
        checks++; if (branch_cnt !== 16'h0) begin failures++; $display("FAIL mid_bcnt got=%0h exp=0", branch_cnt); end
        step();
        rst_n = 1'b1;
        drive_idle();
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            if_pc      = $urandom;
            if_valid   = 1'($urandom_range(0, 3) != 0);
            stall      = 1'($urandom_range(0, 9) == 0);
            flush      = 1'($urandom_range(0, 19) == 0);
            res_opcode = ($urandom_range(0, 3) != 0) ? OP_BR : 7'($urandom);
            res_taken  = 1'($urandom);
            stat_clr   = 1'($urandom_range(0, 99) == 0);
            #1;
            checks++; if (predict_taken !== m_pt()) begin failures++; $display("FAIL rnd_pred[%0d] got=%0b exp=%0b", n, predict_taken, m_pt()); end
            checks++; if (pred_ex_mem !== m_pem()) begin failures++; $display("FAIL rnd_pem[%0d] got=%0b exp=%0b", n, pred_ex_mem, m_pem()); end
            checks++; if (mispredict !== m_misp()) begin failures++; $display("FAIL rnd_misp[%0d] got=%0b exp=%0b", n, mispredict, m_misp()); end
            step();
            checks++; if (branch_cnt !== 16'(mbr)) begin failures++; $display("FAIL rnd_bcnt[%0d] got=%0h exp=%0h", n, branch_cnt, mbr); end
            checks++; if (miss_cnt !== 16'(mmiss)) begin failures++; $display("FAIL rnd_mcnt[%0d] got=%0h exp=%0h", n, miss_cnt, mmiss); end
        end
        drive_idle();
        step();
    endtask

    task automatic test_saturate();
        stat_clr = 1'b1;
        step();
        stat_clr   = 1'b0;
        if_pc      = 32'h4c;
        if_valid   = 1'b1;
        res_opcode = OP_BR;
        for (int n = 0; n < 70000 && mmiss < 65535; n++) begin
            res_taken = !ms[2].pred;
            step();
        end
        checks++; if (mmiss < 65535) begin failures++; $display("FAIL sat_budget got=%0d exp=65535", mmiss); end
        checks++; if (miss_cnt !== 16'(mmiss)) begin failures++; $display("FAIL sat_fill got=%0h exp=%0h", miss_cnt, mmiss); end
        res_taken = !ms[2].pred;
        #1;
        checks++; if (mispredict !== m_misp()) begin failures++; $display("FAIL sat_misp got=%0b exp=%0b", mispredict, m_misp()); end
        step();
        checks++; if (miss_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%0h exp=ffff", miss_cnt); end
        checks++; if (branch_cnt !== 16'(mbr)) begin failures++; $display("FAIL sat_bcnt got=%0h exp=%0h", branch_cnt, mbr); end
        res_taken = !ms[2].pred;
        stat_clr  = 1'b1;
        #1;
        checks++; if (mispredict !== m_misp()) begin failures++; $display("FAIL clr_misp got=%0b exp=%0b", mispredict, m_misp()); end
        step();
        stat_clr = 1'b0;
        checks++; if (branch_cnt !== 16'h0) begin failures++; $display("FAIL clr_bcnt got=%0h exp=0", branch_cnt); end
        checks++; if (miss_cnt !== 16'h0) begin failures++; $display("FAIL clr_mcnt got=%0h exp=0", miss_cnt); end
        drive_idle();
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        if_pc = 32'h0;
        drive_idle();
        model_reset();
        test_reset();
        test_train();
        test_misp_flush();
        test_stall();
        test_flush_stall();
        test_reset_midop();
        test_random();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
